// File: rtl/record_player_pkg.sv
// record_player_pkg: constants shared by the piano record/read-mode blocks.
//   - mode_read        : global mode code for read (playback) mode
//   - n_space .. n_q1  : 3-bit note codes, n_space is silence
//   - oct_*            : 2-bit octave codes
//   - DUR_LSB/NOTE_LSB/OCT_LSB : record RAM entry field offsets, shared with the
//     record (writer) module. note_lsb()/oct_lsb() give the same offsets for a
//     non-default duration width.
package record_player_pkg;

   localparam logic [2:0] mode_read = 3'b111;

   localparam logic [2:0] n_space = 3'd0;
   localparam logic [2:0] n_do    = 3'd1;
   localparam logic [2:0] n_re    = 3'd2;
   localparam logic [2:0] n_mi    = 3'd3;
   localparam logic [2:0] n_fa    = 3'd4;
   localparam logic [2:0] n_so    = 3'd5;
   localparam logic [2:0] n_la    = 3'd6;
   localparam logic [2:0] n_q1    = 3'd7;

   localparam logic [1:0] oct_mid  = 2'b00;
   localparam logic [1:0] oct_high = 2'b01;
   localparam logic [1:0] oct_low  = 2'b10;

   // Entry layout: {octave[1:0], note[2:0], dur[DUR_W-1:0]}
   localparam int unsigned REC_DUR_W = 8;

   function automatic int unsigned note_lsb(input int unsigned dur_w);
      return dur_w;
   endfunction

   function automatic int unsigned oct_lsb(input int unsigned dur_w);
      return dur_w + 3;
   endfunction

   localparam int unsigned DUR_LSB  = 0;
   localparam int unsigned NOTE_LSB = REC_DUR_W;
   localparam int unsigned OCT_LSB  = REC_DUR_W + 3;

endpackage

// File: rtl/record_player_tick_gen.sv
// record_player_tick_gen: free-running prescaler with synchronous clear.
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   clr_i  : synchronous clear; counter restarts from 0 on the next edge
//   tick_o : high for one cycle when the counter sits at TICK_DIV-1
// After a clear the first tick appears TICK_DIV cycles later.
module record_player_tick_gen #(
   parameter int unsigned TICK_DIV = 5_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   output logic tick_o
);

   localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   // tick_o must not depend on clr_i: the owner derives clr_i from a next state
   // that itself depends on tick_o.
   always_comb begin
      tick_o = (cnt_q == CntMax);
      if (clr_i) begin
         cnt_d = '0;
      end else if (cnt_q == CntMax) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/record_player.sv
// record_player: read-mode playback engine. Walks the record RAM from entry 0,
// plays each note for dur ticks (dur 0 counts as 1), inserts GAP_TICKS silent
// ticks between notes and pulses done at the end of each pass.
//   clk, rst_n          : clock, asynchronous active-low reset
//   mode                : global mode; anything but mode_read aborts to IDLE
//   start, stop         : one-cycle command pulses (stop wins over start)
//   rec_len             : number of valid entries, 0..DEPTH
//   rd_en, rd_addr      : RAM read port; rd_data valid one cycle after rd_en
//   play_num_note       : note code to buzzer/LEDs, n_space when silent
//   play_octave         : octave code, oct_mid when silent
//   play_idx            : entry index while playing, 0 otherwise
//   busy                : high outside IDLE and DONE
//   done                : one-cycle pulse when a pass completes
// Build option: define RECORD_PLAYER_LOOP_EN to restart from entry 0 after the
// last entry instead of stopping in DONE (done still pulses once per pass).
module record_player
   import record_player_pkg::*;
#(
   parameter int unsigned DEPTH     = 32,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned DUR_W     = REC_DUR_W,
   parameter int unsigned TICK_DIV  = 5_000_000,
   parameter int unsigned GAP_TICKS = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [2:0]        mode,
   input  logic              start,
   input  logic              stop,
   input  logic [ADDR_W:0]   rec_len,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [4+DUR_W:0]  rd_data,
   output logic [2:0]        play_num_note,
   output logic [1:0]        play_octave,
   output logic [ADDR_W-1:0] play_idx,
   output logic              busy,
   output logic              done
);

   localparam int unsigned NoteLsb = note_lsb(DUR_W);
   localparam int unsigned OctLsb  = oct_lsb(DUR_W);
   localparam int unsigned GapW    = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StWait,
      StPlay,
      StGap,
      StDone
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [2:0]          note_q, note_d;
   logic [1:0]          oct_q, oct_d;
   logic [DUR_W-1:0]    dur_q, dur_d;
   logic [GapW-1:0]     gap_q, gap_d;
   logic                done_q, done_d;

   logic                tick;
   logic                tick_clr;
   logic                abort;
   logic                adv;
   logic                last;
   logic [ADDR_W:0]     idx_inc;
   logic [DUR_W-1:0]    rd_dur;

   assign abort   = stop || (mode != mode_read);
   assign idx_inc = {1'b0, idx_q} + {{ADDR_W{1'b0}}, 1'b1};
   assign last    = (idx_inc >= rec_len);
   assign rd_dur  = rd_data[DUR_LSB +: DUR_W];

   // Prescaler restarts on every state change so each state's first tick
   // lands exactly TICK_DIV cycles after entry.
   assign tick_clr = (state_d != state_q);

   record_player_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (tick_clr),
      .tick_o (tick)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      note_d  = note_q;
      oct_d   = oct_q;
      dur_d   = dur_q;
      gap_d   = gap_q;
      done_d  = 1'b0;
      adv     = 1'b0;

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               if (rec_len == '0) begin
                  state_d = StDone;
                  done_d  = 1'b1;
               end else begin
                  state_d = StFetch;
                  idx_d   = '0;
               end
            end
         end
         StFetch: state_d = StWait;
         StWait: begin
            note_d  = rd_data[NoteLsb +: 3];
            oct_d   = rd_data[OctLsb +: 2];
            dur_d   = (rd_dur == '0) ? DUR_W'(1) : rd_dur;
            state_d = StPlay;
         end
         StPlay: begin
            if (tick) begin
               if (dur_q <= DUR_W'(1)) begin
                  if (GAP_TICKS == 0) begin
                     adv = 1'b1;
                  end else begin
                     state_d = StGap;
                     gap_d   = GapW'(GAP_TICKS);
                  end
               end else begin
                  dur_d = dur_q - 1'b1;
               end
            end
         end
         StGap: begin
            if (tick) begin
               if (gap_q <= GapW'(1)) begin
                  adv = 1'b1;
               end else begin
                  gap_d = gap_q - 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (adv) begin
         if (!last) begin
            state_d = StFetch;
            idx_d   = idx_inc[ADDR_W-1:0];
         end else begin
            done_d = 1'b1;
`ifdef RECORD_PLAYER_LOOP_EN
            state_d = StFetch;
            idx_d   = '0;
`else
            state_d = StDone;
`endif
         end
      end

      if (abort) begin
         state_d = StIdle;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         note_q  <= n_space;
         oct_q   <= oct_mid;
         dur_q   <= '0;
         gap_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         note_q  <= note_d;
         oct_q   <= oct_d;
         dur_q   <= dur_d;
         gap_q   <= gap_d;
         done_q  <= done_d;
      end
   end

   // Outputs decode from registered state only, so reset silences them at once.
   always_comb begin
      rd_en         = (state_q == StFetch);
      rd_addr       = idx_q;
      play_num_note = n_space;
      play_octave   = oct_mid;
      play_idx      = '0;
      if (state_q == StPlay) begin
         play_num_note = note_q;
         play_octave   = oct_q;
         play_idx      = idx_q;
      end
      busy = !(state_q inside {StIdle, StDone});
      done = done_q;
   end

endmodule
